// File: rtl/apb_calc_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the APB calculator slave: register map, ALU op codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_calc_pkg;

  // Word-aligned register map
  localparam logic [15:0] ADDR_A      = 16'h0000;
  localparam logic [15:0] ADDR_B      = 16'h0004;
  localparam logic [15:0] ADDR_CTRL   = 16'h0008;
  localparam logic [15:0] ADDR_C      = 16'h000C;
  localparam logic [15:0] ADDR_STATUS = 16'h0010;

  // CTRL[1:0] operation select for REG_C
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_AND = 2'b11
  } op_t;

  // Transfer FSM
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/apb_calc_if.sv
`timescale 1ns/1ps
// APB bus bundle between the lab-bus initiator and the calculator slave.
// Latency: n/a (wires only).
// Backpressure: slave stretches transfers by holding oPready low.
interface apb_calc_if;
  logic        iPsel;
  logic        iPenable;
  logic        iPwrite;
  logic [15:0] iPaddr;
  logic [31:0] iPwdata;
  logic [31:0] oPrdata;
  logic        oPready;
  logic        oPslverr;

  modport master (
    output iPsel, iPenable, iPwrite, iPaddr, iPwdata,
    input  oPrdata, oPready, oPslverr
  );

  modport slave (
    input  iPsel, iPenable, iPwrite, iPaddr, iPwdata,
    output oPrdata, oPready, oPslverr
  );
endinterface

// File: rtl/apb_calc_alu.sv
`timescale 1ns/1ps
// Combinational 32-bit operation select feeding the REG_C flop.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
import apb_calc_pkg::*;

module apb_calc_alu (
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  op_t         opSel,
  output logic [31:0] result
);

  // Add/sub wrap mod 2^32; carry and borrow are intentionally dropped
  always_comb begin
    result = '0;
    case (opSel)
      OP_ADD:  result = opA + opB;
      OP_SUB:  result = opA - opB;
      OP_XOR:  result = opA ^ opB;
      OP_AND:  result = opA & opB;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/apb_calc_slave.sv
`timescale 1ns/1ps
// APB slave with operand/control registers, a registered ALU result and transfer counters.
// Latency: WAIT_CYCLES+2 cycles per transfer (setup + WAIT_CYCLES+1 access cycles).
// Backpressure: oPready held low for WAIT_CYCLES access cycles; iPsel drop during access aborts.
import apb_calc_pkg::*;

module apb_calc_slave #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       iClk,
  input  logic       iRsn,
  apb_calc_if.slave  bus
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t      state;
  state_t      stateNext;
  logic [3:0]  cnt;
  logic [3:0]  cntNext;

  logic [31:0] regA;
  logic [31:0] regB;
  logic [1:0]  ctrl;
  logic [31:0] regC;
  logic [15:0] rdCount;
  logic [15:0] wrCount;

  logic [31:0] aluRes;
  logic [31:0] readVal;
  logic        addrErr;
  logic        ready;
  logic        wrEn;
  logic        rdEn;

  apb_calc_alu uAlu (
    .opA    (regA),
    .opB    (regB),
    .opSel  (op_t'(ctrl)),
    .result (aluRes)
  );

  // FSM state and wait counter registers
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next state: setup loads the wait count, access counts down, iPsel drop aborts
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      ST_IDLE: begin
        if (bus.iPsel && !bus.iPenable) begin
          stateNext = ST_ACCESS;
          cntNext   = WAIT_LOAD;
        end
      end
      ST_ACCESS: begin
        if (!bus.iPsel) begin
          stateNext = ST_IDLE;
        end else if (bus.iPenable) begin
          if (cnt != 4'd0) cntNext = cnt - 4'd1;
          else             stateNext = ST_IDLE;
        end
        // iPsel=1, iPenable=0 here is an initiator violation: hold quietly
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Address decode: read mux plus error on unmapped, misaligned or read-only writes
  always_comb begin
    readVal = '0;
    addrErr = 1'b0;
    if (bus.iPaddr[1:0] != 2'b00) begin
      addrErr = 1'b1;
    end else begin
      case (bus.iPaddr)
        ADDR_A:      readVal = regA;
        ADDR_B:      readVal = regB;
        ADDR_CTRL:   readVal = {30'd0, ctrl};
        ADDR_C: begin
          readVal = regC;
          addrErr = bus.iPwrite;
        end
        ADDR_STATUS: begin
          readVal = {rdCount, wrCount};
          addrErr = bus.iPwrite;
        end
        default:     addrErr = 1'b1;
      endcase
    end
  end

  // FSM outputs: response fields are forced to 0 outside the completing cycle
  always_comb begin
    ready        = (state == ST_ACCESS) && (cnt == 4'd0) && bus.iPsel && bus.iPenable;
    wrEn         = ready && bus.iPwrite && !addrErr;
    rdEn         = ready && !bus.iPwrite && !addrErr;
    bus.oPready  = ready;
    bus.oPslverr = ready && addrErr;
    bus.oPrdata  = rdEn ? readVal : 32'd0;
  end

  // Writable registers commit on the completing edge of a good write
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      regA <= '0;
      regB <= '0;
      ctrl <= '0;
    end else if (wrEn) begin
      case (bus.iPaddr)
        ADDR_A:    regA <= bus.iPwdata;
        ADDR_B:    regB <= bus.iPwdata;
        ADDR_CTRL: ctrl <= bus.iPwdata[1:0];
        default:   ;
      endcase
    end
  end

  // REG_C tracks the ALU one cycle behind its operands
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) regC <= '0;
    else       regC <= aluRes;
  end

  // Transfer counters: successful transfers only, 16-bit wrap
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      rdCount <= '0;
      wrCount <= '0;
    end else begin
      if (rdEn) rdCount <= rdCount + 16'd1;
      if (wrEn) wrCount <= wrCount + 16'd1;
    end
  end

endmodule
